// File: rtl/axi_sim_pkg.sv
// Shared AXI4 channel structs and encodings for the simulation memory slave.
// Struct widths match the fabric defaults: 4-bit id, 64-bit data, 32-bit address.
package axi_sim_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

  // Protocol errors outrank decode errors in the write response.
  function automatic logic [1:0] wr_resp(input logic slverr, input logic decerr);
    if (slverr) return RESP_SLVERR;
    if (decerr) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_sim_mem_slave_addr_gen.sv
// Per-channel burst address generator: word index, range check and burst-type error.
// The full-width index is kept so a burst walking off the array end reports out of range.
module axi_sim_addr_gen
  import axi_sim_pkg::*;
#(
  parameter int                      AxiAddrWidth = 32,
  parameter int                      AxiDataWidth = 64,
  parameter int                      MEM_WORDS    = 1024,
  parameter logic [AxiAddrWidth-1:0] BASE_ADDR    = '0
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          load,
  input  logic [AxiAddrWidth-1:0]       addr,
  input  logic [1:0]                    burst,
  input  logic                          advance,
  output logic [$clog2(MEM_WORDS)-1:0]  idx,
  output logic                          oor,
  output logic                          wrap_err
);

  localparam int OffW = $clog2(AxiDataWidth / 8);
  localparam int IdxW = $clog2(MEM_WORDS);

  logic [AxiAddrWidth-1:0] word_idx;
  logic                    underflow;
  logic [1:0]              burst_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      word_idx  <= '0;
      underflow <= 1'b0;
      burst_q   <= BURST_FIXED;
    end else if (load) begin
      word_idx  <= (addr - BASE_ADDR) >> OffW;
      underflow <= (addr < BASE_ADDR);
      burst_q   <= burst;
    end else if (advance && (burst_q == BURST_INCR)) begin
      word_idx <= word_idx + AxiAddrWidth'(1);
    end
  end

  assign idx      = word_idx[IdxW-1:0];
  assign oor      = underflow || (word_idx >= AxiAddrWidth'(MEM_WORDS));
  // WRAP and the reserved encoding both have bit 1 set.
  assign wrap_err = burst_q[1];

endmodule

// File: rtl/axi_sim_mem_slave.sv
// AXI4 slave backed by a word array; independent read and write FSMs.
// Reads are combinational from the array, so a same-cycle write is seen on the next beat.
module axi_sim_mem_slave
  import axi_sim_pkg::*;
#(
  parameter int                      AxiIdWidth   = 4,
  parameter int                      AxiDataWidth = 64,
  parameter int                      AxiAddrWidth = 32,
  parameter int                      MEM_WORDS    = 1024,
  parameter logic [AxiAddrWidth-1:0] BASE_ADDR    = '0,
  parameter type                     req_t        = axi_req_t,
  parameter type                     resp_t       = axi_resp_t
) (
  input  logic  clk,
  input  logic  arstn,
  input  req_t  s_axi_req_i,
  output resp_t s_axi_resp_o
);

  localparam int IdxW  = $clog2(MEM_WORDS);
  localparam int StrbW = AxiDataWidth / 8;

  logic [AxiDataWidth-1:0] mem [MEM_WORDS];

  // ---------------- read channel ----------------
  rd_state_t             rd_state;
  logic                  ar_ready, r_valid;
  logic [AxiIdWidth-1:0] r_id;
  logic [7:0]            r_len, r_cnt;
  logic [IdxW-1:0]       r_idx;
  logic                  r_oor, r_wrap_err;
  logic                  ar_hs, r_hs;
  logic [AxiDataWidth-1:0] r_data;
  logic [1:0]            r_resp;

  assign ar_hs = s_axi_req_i.ar_valid && ar_ready;
  assign r_hs  = r_valid && s_axi_req_i.r_ready;

  axi_sim_addr_gen #(
    .AxiAddrWidth(AxiAddrWidth), .AxiDataWidth(AxiDataWidth),
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_rd_addr (
    .clk(clk), .arstn(arstn), .load(ar_hs),
    .addr(s_axi_req_i.ar.addr), .burst(s_axi_req_i.ar.burst), .advance(r_hs),
    .idx(r_idx), .oor(r_oor), .wrap_err(r_wrap_err)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rd_state <= RD_IDLE;
      ar_ready <= 1'b1;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (ar_hs) begin
          rd_state <= RD_DATA;
          ar_ready <= 1'b0;
          r_valid  <= 1'b1;
          r_id     <= s_axi_req_i.ar.id;
          r_len    <= s_axi_req_i.ar.len;
          r_cnt    <= '0;
        end
        RD_DATA: if (r_hs) begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == r_len) begin
            rd_state <= RD_IDLE;
            ar_ready <= 1'b1;
            r_valid  <= 1'b0;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    r_data = '0;
    r_resp = RESP_OKAY;
    if (r_wrap_err)  r_resp = RESP_SLVERR;
    else if (r_oor)  r_resp = RESP_DECERR;
    else             r_data = mem[r_idx];
  end

  // ---------------- write channel ----------------
  wr_state_t             wr_state;
  logic                  aw_ready, w_ready, b_valid;
  logic [AxiIdWidth-1:0] b_id;
  logic [7:0]            w_len, w_cnt;
  logic                  slverr_flag, decerr_flag;
  logic [IdxW-1:0]       w_idx;
  logic                  w_oor, w_wrap_err;
  logic                  aw_hs, w_hs, b_hs, mem_we;

  assign aw_hs  = s_axi_req_i.aw_valid && aw_ready;
  assign w_hs   = s_axi_req_i.w_valid && w_ready;
  assign b_hs   = b_valid && s_axi_req_i.b_ready;
  assign mem_we = w_hs && !w_oor && !w_wrap_err;

  axi_sim_addr_gen #(
    .AxiAddrWidth(AxiAddrWidth), .AxiDataWidth(AxiDataWidth),
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_wr_addr (
    .clk(clk), .arstn(arstn), .load(aw_hs),
    .addr(s_axi_req_i.aw.addr), .burst(s_axi_req_i.aw.burst), .advance(w_hs),
    .idx(w_idx), .oor(w_oor), .wrap_err(w_wrap_err)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_state    <= WR_IDLE;
      aw_ready    <= 1'b1;
      w_ready     <= 1'b0;
      b_valid     <= 1'b0;
      b_id        <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      slverr_flag <= 1'b0;
      decerr_flag <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (aw_hs) begin
          wr_state <= WR_DATA;
          aw_ready <= 1'b0;
          w_ready  <= 1'b1;
          b_id     <= s_axi_req_i.aw.id;
          w_len    <= s_axi_req_i.aw.len;
          w_cnt    <= '0;
        end
        WR_DATA: if (w_hs) begin
          w_cnt <= w_cnt + 8'd1;
          // Beat count must equal len+1: early last, or a non-last beat at len, is a protocol error.
          if (w_wrap_err || (s_axi_req_i.w.last ? (w_cnt != w_len) : (w_cnt == w_len)))
            slverr_flag <= 1'b1;
          if (w_oor) decerr_flag <= 1'b1;
          if (s_axi_req_i.w.last) begin
            wr_state <= WR_RESP;
            w_ready  <= 1'b0;
            b_valid  <= 1'b1;
          end
        end
        WR_RESP: if (b_hs) begin
          wr_state    <= WR_IDLE;
          b_valid     <= 1'b0;
          aw_ready    <= 1'b1;
          slverr_flag <= 1'b0;
          decerr_flag <= 1'b0;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < StrbW; i++) begin
        if (s_axi_req_i.w.strb[i]) mem[w_idx][i*8 +: 8] <= s_axi_req_i.w.data[i*8 +: 8];
      end
    end
  end

  logic unused_size;
  assign unused_size = ^{s_axi_req_i.ar.size, s_axi_req_i.aw.size};

  always_comb begin
    s_axi_resp_o          = '0;
    s_axi_resp_o.ar_ready = ar_ready;
    s_axi_resp_o.aw_ready = aw_ready;
    s_axi_resp_o.w_ready  = w_ready;
    s_axi_resp_o.r_valid  = r_valid;
    s_axi_resp_o.r.id     = r_id;
    s_axi_resp_o.r.data   = r_data;
    s_axi_resp_o.r.resp   = r_resp;
    s_axi_resp_o.r.last   = (r_cnt == r_len);
    s_axi_resp_o.b_valid  = b_valid;
    s_axi_resp_o.b.id     = b_id;
    s_axi_resp_o.b.resp   = wr_resp(slverr_flag, decerr_flag);
  end

endmodule

// File: tb/tb_axi_sim_mem_slave.sv
// Scoreboard bench for axi_sim_mem_slave: expected R/B beats queued at issue, checked at the DUT.
module tb_axi_sim_mem_slave;
  import axi_sim_pkg::*;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h0;

  logic      clk = 1'b0;
  logic      arstn;
  axi_req_t  req;
  axi_resp_t resp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  logic [63:0] wq[$];
  logic [63:0] model_mem [int];

  axi_sim_mem_slave #(
    .AxiIdWidth(4), .AxiDataWidth(64), .AxiAddrWidth(32),
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .arstn(arstn), .s_axi_req_i(req), .s_axi_resp_o(resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 3);
  endfunction

  function automatic bit in_range(input logic [31:0] addr, input int w);
    return (addr >= BASE) && (w >= 0) && (w < MEM_WORDS);
  endfunction

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic [1:0] burst);
    int wt;
    wt = 0;
    for (int i = 0; i <= int'(len); i++) begin
      r_exp_t e;
      int     w;
      w      = word_of(addr) + ((burst == BURST_INCR) ? i : 0);
      e.id   = id;
      e.last = (i == int'(len));
      if (burst[1]) begin
        e.data = 64'h0; e.resp = RESP_SLVERR;
      end else if (!in_range(addr, w)) begin
        e.data = 64'h0; e.resp = RESP_DECERR;
      end else begin
        e.data = model_mem.exists(w) ? model_mem[w] : 64'h0; e.resp = RESP_OKAY;
      end
      rq.push_back(e);
    end
    req.ar.addr = addr; req.ar.len = len; req.ar.id = id;
    req.ar.burst = burst; req.ar.size = 3'd3; req.ar_valid = 1'b1;
    while (!resp.ar_ready && wt < 50) begin @(negedge clk); wt++; end
    @(negedge clk);
    req.ar_valid = 1'b0;
    total_cnt++;
    if (wt >= 50) $display("FAIL ar_handshake: ar_ready stayed %b, required 1", resp.ar_ready);
    else pass_cnt++;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic [1:0] burst);
    int wt;
    wt = 0;
    req.aw.addr = addr; req.aw.len = len; req.aw.id = id;
    req.aw.burst = burst; req.aw.size = 3'd3; req.aw_valid = 1'b1;
    while (!resp.aw_ready && wt < 50) begin @(negedge clk); wt++; end
    @(negedge clk);
    req.aw_valid = 1'b0;
    total_cnt++;
    if (wt >= 50) $display("FAIL aw_handshake: aw_ready stayed %b, required 1", resp.aw_ready);
    else pass_cnt++;
  endtask

  // Sends the beats in wq; the last one carries w.last. Queues the expected B.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] id, input logic [1:0] burst,
                             input logic [7:0] strb);
    b_exp_t e;
    bit     dec, slv;
    dec = 1'b0; slv = 1'b0;
    send_aw(addr, len, id, burst);
    for (int i = 0; i < wq.size(); i++) begin
      int          w, wt;
      logic [63:0] cur;
      wt = 0;
      w  = word_of(addr) + ((burst == BURST_INCR) ? i : 0);
      if (burst[1]) slv = 1'b1;
      else if (!in_range(addr, w)) dec = 1'b1;
      else begin
        cur = model_mem.exists(w) ? model_mem[w] : 64'h0;
        for (int b = 0; b < 8; b++) if (strb[b]) cur[b*8 +: 8] = wq[i][b*8 +: 8];
        model_mem[w] = cur;
      end
      req.w.data = wq[i]; req.w.strb = strb; req.w.last = (i == wq.size() - 1);
      req.w_valid = 1'b1;
      while (!resp.w_ready && wt < 50) begin @(negedge clk); wt++; end
      @(negedge clk);
      req.w_valid = 1'b0;
      total_cnt++;
      if (wt >= 50) $display("FAIL w_handshake: w_ready stayed %b, required 1", resp.w_ready);
      else pass_cnt++;
    end
    if (wq.size() != int'(len) + 1) slv = 1'b1;
    e.id   = id;
    e.resp = slv ? RESP_SLVERR : (dec ? RESP_DECERR : RESP_OKAY);
    bq.push_back(e);
  endtask

  // Called right after the w.last handshake; holds b_ready low for 'hold' cycles.
  task automatic collect_b(input int hold);
    b_exp_t e;
    int     wt;
    wt = 0;
    total_cnt++;
    if (resp.b_valid !== 1'b1) $display("FAIL b_valid_after_last: b_valid=%b required 1", resp.b_valid);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      req.b_ready = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (resp.b_valid !== 1'b1 || resp.aw_ready !== 1'b0)
        $display("FAIL b_hold: b_valid=%b aw_ready=%b required 1/0", resp.b_valid, resp.aw_ready);
      else pass_cnt++;
    end
    req.b_ready = 1'b1;
    while (!resp.b_valid && wt < 50) begin @(negedge clk); wt++; end
    total_cnt++;
    if (bq.size() == 0 || wt >= 50) begin
      $display("FAIL b_resp: no B response or no expectation (queued=%0d)", bq.size());
    end else begin
      e = bq.pop_front();
      if ({resp.b.id, resp.b.resp} !== {e.id, e.resp})
        $display("FAIL b_resp: id=%h resp=%b required id=%h resp=%b", resp.b.id, resp.b.resp, e.id, e.resp);
      else pass_cnt++;
    end
    @(negedge clk);
    req.b_ready = 1'b0;
    total_cnt++;
    if (resp.b_valid !== 1'b0 || resp.aw_ready !== 1'b1)
      $display("FAIL b_release: b_valid=%b aw_ready=%b required 0/1", resp.b_valid, resp.aw_ready);
    else pass_cnt++;
  endtask

  // r_ready follows pat (bit cyc%4); every valid cycle is compared with the queue head.
  task automatic recv_r(input int n, input logic [3:0] pat);
    int got, cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      req.r_ready = pat[cyc % 4];
      if (resp.r_valid === 1'b1 && rq.size() > 0) begin
        total_cnt++;
        if ({resp.r.id, resp.r.data, resp.r.resp, resp.r.last} !==
            {rq[0].id, rq[0].data, rq[0].resp, rq[0].last})
          $display("FAIL r_beat%0d: id=%h data=%h resp=%b last=%b required id=%h data=%h resp=%b last=%b",
                   got, resp.r.id, resp.r.data, resp.r.resp, resp.r.last,
                   rq[0].id, rq[0].data, rq[0].resp, rq[0].last);
        else pass_cnt++;
        if (req.r_ready) begin rq.delete(0); got++; end
      end
      @(negedge clk);
      cyc++;
    end
    req.r_ready = 1'b0;
    total_cnt++;
    if (got != n || resp.r_valid !== 1'b0 || resp.ar_ready !== 1'b1)
      $display("FAIL r_done: beats=%0d r_valid=%b ar_ready=%b required %0d/0/1",
               got, resp.r_valid, resp.ar_ready, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({resp.ar_ready, resp.aw_ready, resp.w_ready, resp.r_valid, resp.b_valid} !== 5'b11000)
      $display("FAIL reset_state: ar/aw/w/r/b=%b required 11000",
               {resp.ar_ready, resp.aw_ready, resp.w_ready, resp.r_valid, resp.b_valid});
    else pass_cnt++;
  endtask

  task automatic test_incr_write_read();
    wq.delete();
    wq.push_back(64'h11); wq.push_back(64'h22); wq.push_back(64'h33); wq.push_back(64'h44);
    write_burst(32'h40, 8'd3, 4'h5, BURST_INCR, 8'hFF);
    collect_b(0);
    send_ar(32'h40, 8'd3, 4'h5, BURST_INCR);
    recv_r(4, 4'b1111);
  endtask

  task automatic test_byte_strobe();
    wq.delete(); wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    write_burst(32'h0, 8'd0, 4'h1, BURST_INCR, 8'hFF);
    collect_b(0);
    wq.delete(); wq.push_back(64'h0);
    write_burst(32'h0, 8'd0, 4'h1, BURST_INCR, 8'h0F);
    collect_b(0);
    send_ar(32'h0, 8'd0, 4'h1, BURST_INCR);
    recv_r(1, 4'b1111);
  endtask

  task automatic test_out_of_range();
    send_ar(BASE + MEM_WORDS * 8, 8'd1, 4'h9, BURST_INCR);
    recv_r(2, 4'b1111);
    wq.delete(); wq.push_back(64'h0BAD_0BAD_0BAD_0BAD);
    write_burst(BASE + MEM_WORDS * 8, 8'd0, 4'h9, BURST_INCR, 8'hFF);
    collect_b(0);
    send_ar(32'h0, 8'd0, 4'h9, BURST_INCR);
    recv_r(1, 4'b1111);
  endtask

  task automatic test_wrap();
    send_ar(32'h40, 8'd1, 4'h7, BURST_WRAP);
    recv_r(2, 4'b1111);
    wq.delete(); wq.push_back(64'hDEAD_BEEF);
    write_burst(32'h40, 8'd0, 4'h7, BURST_WRAP, 8'hFF);
    collect_b(0);
    send_ar(32'h40, 8'd0, 4'h7, BURST_FIXED);
    recv_r(1, 4'b1111);
  endtask

  task automatic test_backpressure();
    send_ar(32'h40, 8'd3, 4'h5, BURST_INCR);
    recv_r(4, 4'b1001);
    wq.delete(); wq.push_back(64'h00C0_FFEE);
    write_burst(32'h80, 8'd0, 4'hC, BURST_INCR, 8'hFF);
    collect_b(5);
  endtask

  task automatic test_protocol_error();
    wq.delete(); wq.push_back(64'h1); wq.push_back(64'h2);
    write_burst(32'h100, 8'd3, 4'hA, BURST_INCR, 8'hFF);
    collect_b(0);
    send_ar(32'h100, 8'd1, 4'hA, BURST_INCR);
    recv_r(2, 4'b1111);
  endtask

  task automatic test_back_to_back_concurrent();
    r_exp_t e;
    wq.delete(); wq.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    write_burst(32'h200, 8'd0, 4'h1, BURST_INCR, 8'hFF);
    collect_b(0);
    e.id = 4'h2; e.data = model_mem[word_of(32'h200)]; e.resp = RESP_OKAY; e.last = 1'b1;
    req.ar.addr = 32'h200; req.ar.len = 8'd0; req.ar.id = 4'h2; req.ar.burst = BURST_INCR;
    req.aw.addr = 32'h200; req.aw.len = 8'd0; req.aw.id = 4'h6; req.aw.burst = BURST_INCR;
    req.ar_valid = 1'b1; req.aw_valid = 1'b1;
    @(negedge clk);
    req.ar_valid = 1'b0; req.aw_valid = 1'b0;
    total_cnt++;
    if (resp.r_valid !== 1'b1 || resp.w_ready !== 1'b1)
      $display("FAIL concurrent_accept: r_valid=%b w_ready=%b required 1/1", resp.r_valid, resp.w_ready);
    else pass_cnt++;
    req.w.data = 64'h5555_5555_5555_5555; req.w.strb = 8'hFF; req.w.last = 1'b1;
    req.w_valid = 1'b1; req.r_ready = 1'b1;
    total_cnt++;
    if (resp.r.data !== e.data || resp.r.id !== e.id)
      $display("FAIL concurrent_old_data: data=%h id=%h required data=%h id=%h",
               resp.r.data, resp.r.id, e.data, e.id);
    else pass_cnt++;
    @(negedge clk);
    req.w_valid = 1'b0; req.r_ready = 1'b0;
    model_mem[word_of(32'h200)] = 64'h5555_5555_5555_5555;
    bq.push_back('{id: 4'h6, resp: RESP_OKAY});
    collect_b(0);
    send_ar(32'h200, 8'd0, 4'h2, BURST_INCR);
    recv_r(1, 4'b1111);
  endtask

  task automatic test_reset_mid_burst();
    send_ar(32'h40, 8'd3, 4'h3, BURST_INCR);
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    rq.delete();
    arstn = 1'b0;
    #1;
    total_cnt++;
    if (resp.r_valid !== 1'b0) $display("FAIL reset_abort: r_valid=%b required 0", resp.r_valid);
    else pass_cnt++;
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (resp.ar_ready !== 1'b1 || resp.r_valid !== 1'b0)
      $display("FAIL reset_release: ar_ready=%b r_valid=%b required 1/0", resp.ar_ready, resp.r_valid);
    else pass_cnt++;
    send_ar(32'h48, 8'd0, 4'h3, BURST_INCR);
    recv_r(1, 4'b1111);
  endtask

  initial begin
    req   = '0;
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_incr_write_read();
    test_byte_strobe();
    test_out_of_range();
    test_wrap();
    test_backpressure();
    test_protocol_error();
    test_back_to_back_concurrent();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
